acq_trigger_ctrl: RTL and testbench
===================================

# acq_trigger_ctrl

Acquisition sequencer placed ahead of the dual-buffer capture block in the ADC path. It generates the sample strobe and detects the comparator trigger edge. Using normal, auto, single or stop modes, it decides when a new frame capture starts. It also enforces a post-capture holdoff and withholds triggers while the MCU still holds the buffer.

## Interface
- DIV_WIDTH, 16: width of the sample-period divider.
- HOLDOFF_WIDTH, 16: width of the holdoff counter, in sample ticks.
- TIMEOUT_WIDTH, 24: width of the auto-trigger timeout counter, in sample ticks.

Ports:
- clk  in  1  system clock; the block has a single clock domain.
- rst  in  1  asynchronous, active-high reset.
- cfg_div  in  DIV_WIDTH  sample period minus 1, in clk cycles.
- cfg_mode  in  2  0 normal, 1 auto, 2 single, 3 stop.
- cfg_edge  in  2  0 rising, 1 falling, 2 either edge, 3 immediate (no edge required).
- cfg_holdoff  in  HOLDOFF_WIDTH  ticks to wait after a frame before re-arming.
- cfg_timeout  in  TIMEOUT_WIDTH  auto mode: ticks in ARMED before a forced trigger.
- arm  in  1  single mode: one-cycle re-arm pulse.
- cmp_in  in  1  comparator level, already synchronized to clk.
- buf_ready  in  1  high when the buffer consumer is not reading and a capture may start.
- buf_done  in  1  one-cycle pulse from the buffer when the frame is full.
- sample_tick  out  1  one-cycle strobe, once every cfg_div+1 clk cycles.
- capture_start  out  1  one-cycle pulse when a frame starts.
- capture_en  out  1  high for the whole frame.
- forced  out  1  high if the last frame was started by auto timeout.
- state  out  2  IDLE=0, ARMED=1, CAPTURE=2, HOLDOFF=3.
- frame_cnt  out  16  count of completed frames; wraps from FFFF to 0.

## Operation
- Divider
  - div_cnt increments every clk.
  - When div_cnt >= cfg_div: div_cnt returns to 0 and sample_tick is 1 in the next cycle. The >= compare means a live reduction of cfg_div never causes a wrap-around.
  - cfg_div=0 gives sample_tick high continuously.
- Edge detect
  - cmp_prev is loaded with cmp_in on every tick, in every state.
  - On a tick: rise = cmp_in & ~cmp_prev; fall = ~cmp_in & cmp_prev.
  - Edge hit is selected by cfg_edge; cfg_edge=3 means the hit is always true.
- FSM
  - IDLE: go to ARMED if cfg_mode is 0 or 1, or if cfg_mode is 2 and arm=1. In cfg_mode 3, stay in IDLE.
  - ARMED: on a tick with buf_ready=1:
    - Edge hit: go to CAPTURE, pulse capture_start, forced<=0.
    - Otherwise, if cfg_mode=1 and to_cnt >= cfg_timeout: go to CAPTURE, pulse capture_start, forced<=1.
    - to_cnt clears on entry to ARMED, increments on each tick and saturates at all-ones.
    - While buf_ready=0, triggers are ignored but to_cnt keeps counting.
  - CAPTURE: capture_en=1. On buf_done, frame_cnt increments, then:
    - cfg_mode 2 or 3: go to IDLE.
    - Otherwise: go to HOLDOFF, ho_cnt<=0.
  - HOLDOFF: ho_cnt increments on each tick. When ho_cnt >= cfg_holdoff, go to ARMED; with cfg_holdoff=0 this happens on the next cycle.
- Abort: cfg_mode=3 in ARMED, CAPTURE or HOLDOFF forces IDLE on the next cycle and drops capture_en.
- Simultaneous events:
  - buf_done and stop in the same cycle: the frame is counted, then the FSM goes to IDLE.
  - arm outside IDLE is ignored.
  - buf_done outside CAPTURE is ignored.
  - A mode change from single to normal takes effect at the next decision point.
- Configuration inputs are used live and are not latched.

## Timing
- Reset values: sample_tick=0, capture_start=0, capture_en=0, forced=0, state=IDLE, frame_cnt=0. Internally div_cnt=0, cmp_prev=0, to_cnt=0, ho_cnt=0.
- All outputs are registered.
- Trigger latency: tick and hit in cycle T, then capture_start=1 and capture_en=1 in cycle T+1. capture_start lasts exactly one cycle.
- Frame end: buf_done in cycle D, then capture_en=0 and frame_cnt updated in cycle D+1.
- Minimum retrigger interval after buf_done: one cycle into HOLDOFF, plus cfg_holdoff ticks, plus at least one tick in ARMED.
- Reset asserted mid-frame drops capture_en immediately (asynchronous reset). The downstream buffer is expected to discard its partial frame.

## Test plan
- Normal rising edge. Setup: cfg_div=3, cfg_edge=0, cfg_holdoff=2, buf_ready=1; toggle cmp_in every 20 clk; pulse buf_done 40 clk after each capture_start. Required:
  - sample_tick every 4 clk.
  - capture_start one cycle after the first tick with cmp_in=1.
  - frame_cnt=3 after 3 frames.
  - No trigger during HOLDOFF.
- Auto timeout. Setup: cfg_mode=1, cfg_timeout=10, cmp_in held at 0. Required: capture_start after the 11th tick in ARMED, with forced=1. A later genuine edge gives forced=0.
- Single mode. Setup: cfg_mode=2. Required:
  - Stays IDLE until an arm pulse.
  - After one frame, returns to IDLE with frame_cnt=1.
  - A second edge without arm produces no capture_start.
- buf_ready gating. Setup: hold buf_ready=0 through 3 edges, then release. Required: no capture while held; capture on the first edge tick after release; a stale edge does not trigger.
- Abort and boundaries. Setup: set cfg_mode=3 mid-CAPTURE; separately, buf_done in the same cycle as stop; then assert rst mid-frame; then run cfg_div=0 and 65536 frames. Required:
  - Abort: capture_en low next cycle, state=0, frame_cnt unchanged.
  - buf_done with stop: frame_cnt increments, state goes to IDLE.
  - rst mid-frame: all outputs at reset values immediately.
  - cfg_div=0: sample_tick stays high continuously.
  - 65536 frames: frame_cnt wraps to 0.

Source files
------------

// File: rtl/acq_trigger_ctrl.sv
// Acquisition sequencer: sample-strobe divider, comparator edge trigger, frame FSM with holdoff.
// Latency: tick+hit in cycle T gives capture_start/capture_en in T+1; buf_done in D drops capture_en in D+1.
// Backpressure: buf_ready=0 withholds triggers in ARMED while the auto timeout keeps counting.
module acq_trigger_ctrl #(
  parameter int DIV_WIDTH     = 16,
  parameter int HOLDOFF_WIDTH = 16,
  parameter int TIMEOUT_WIDTH = 24
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DIV_WIDTH-1:0]     cfg_div,
  input  logic [1:0]               cfg_mode,
  input  logic [1:0]               cfg_edge,
  input  logic [HOLDOFF_WIDTH-1:0] cfg_holdoff,
  input  logic [TIMEOUT_WIDTH-1:0] cfg_timeout,
  input  logic                     arm,
  input  logic                     cmp_in,
  input  logic                     buf_ready,
  input  logic                     buf_done,
  output logic                     sample_tick,
  output logic                     capture_start,
  output logic                     capture_en,
  output logic                     forced,
  output logic [1:0]               state,
  output logic [15:0]              frame_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    HOLDOFF = 2'd3
  } state_e;

  localparam logic [1:0] MODE_NORMAL = 2'd0;
  localparam logic [1:0] MODE_AUTO   = 2'd1;
  localparam logic [1:0] MODE_SINGLE = 2'd2;
  localparam logic [1:0] MODE_STOP   = 2'd3;

  localparam logic [1:0] EDGE_RISE = 2'd0;
  localparam logic [1:0] EDGE_FALL = 2'd1;
  localparam logic [1:0] EDGE_ANY  = 2'd2;
  localparam logic [1:0] EDGE_IMM  = 2'd3;

  localparam logic [DIV_WIDTH-1:0]     DIV_ONE = {{(DIV_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [HOLDOFF_WIDTH-1:0] HO_ONE  = {{(HOLDOFF_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [TIMEOUT_WIDTH-1:0] TO_ONE  = {{(TIMEOUT_WIDTH-1){1'b0}}, 1'b1};

  logic [DIV_WIDTH-1:0]     div_cnt_q, div_cnt_d;
  logic                     tick_q, tick_d;
  logic                     cmp_prev_q;
  logic                     rise, fall, hit, timeout_hit;
  logic [TIMEOUT_WIDTH-1:0] to_cnt_q;
  logic [HOLDOFF_WIDTH-1:0] ho_cnt_q;
  state_e                   state_q;
  logic                     start_q, en_q, forced_q;
  logic [15:0]              frame_cnt_q;

  // Divider next state: >= compare so a live cfg_div reduction never wraps the counter
  always_comb begin
    if (div_cnt_q >= cfg_div) begin
      div_cnt_d = '0;
      tick_d    = 1'b1;
    end else begin
      div_cnt_d = div_cnt_q + DIV_ONE;
      tick_d    = 1'b0;
    end
  end

  // Edge classification against the level seen on the previous tick
  always_comb begin
    rise        = cmp_in & ~cmp_prev_q;
    fall        = ~cmp_in & cmp_prev_q;
    hit         = 1'b0;
    timeout_hit = (cfg_mode == MODE_AUTO) && (to_cnt_q >= cfg_timeout);
    unique case (cfg_edge)
      EDGE_RISE: hit = rise;
      EDGE_FALL: hit = fall;
      EDGE_ANY:  hit = rise | fall;
      EDGE_IMM:  hit = 1'b1;
    endcase
  end

  // Divider counter, tick strobe and per-tick comparator history (all states)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q  <= '0;
      tick_q     <= 1'b0;
      cmp_prev_q <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      tick_q    <= tick_d;
      if (tick_q) cmp_prev_q <= cmp_in;
    end
  end

  // Acquisition FSM with registered outputs; stop aborts everything except a same-cycle frame end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      start_q     <= 1'b0;
      en_q        <= 1'b0;
      forced_q    <= 1'b0;
      frame_cnt_q <= '0;
      to_cnt_q    <= '0;
      ho_cnt_q    <= '0;
    end else begin
      start_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (cfg_mode == MODE_NORMAL || cfg_mode == MODE_AUTO ||
              (cfg_mode == MODE_SINGLE && arm)) begin
            state_q  <= ARMED;
            to_cnt_q <= '0;
          end
        end
        ARMED: begin
          if (cfg_mode == MODE_STOP) begin
            state_q <= IDLE;
          end else if (tick_q && buf_ready && (hit || timeout_hit)) begin
            state_q  <= CAPTURE;
            start_q  <= 1'b1;
            en_q     <= 1'b1;
            forced_q <= ~hit;
          end
          if (tick_q && (to_cnt_q != '1)) to_cnt_q <= to_cnt_q + TO_ONE;
        end
        CAPTURE: begin
          if (buf_done) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
            en_q        <= 1'b0;
            if (cfg_mode == MODE_SINGLE || cfg_mode == MODE_STOP) begin
              state_q <= IDLE;
            end else begin
              state_q  <= HOLDOFF;
              ho_cnt_q <= '0;
            end
          end else if (cfg_mode == MODE_STOP) begin
            state_q <= IDLE;
            en_q    <= 1'b0;
          end
        end
        HOLDOFF: begin
          if (cfg_mode == MODE_STOP) begin
            state_q <= IDLE;
          end else if (ho_cnt_q >= cfg_holdoff) begin
            state_q  <= ARMED;
            to_cnt_q <= '0;
          end else if (tick_q) begin
            ho_cnt_q <= ho_cnt_q + HO_ONE;
          end
        end
      endcase
    end
  end

  assign sample_tick   = tick_q;
  assign capture_start = start_q;
  assign capture_en    = en_q;
  assign forced        = forced_q;
  assign state         = state_q;
  assign frame_cnt     = frame_cnt_q;

endmodule

// File: tb/tb_acq_trigger_ctrl.sv
`timescale 1ns/1ps
// Bench for acq_trigger_ctrl: scenario tasks plus randomized traffic against a behavioural model.
// The model derives ticks from the cycle count since reset and keeps trigger bookkeeping in plain integers.
// Each task compares the packed output vector every cycle and adds scenario-specific constant checks.
module tb_acq_trigger_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cfg_div;
  logic [1:0]  cfg_mode;
  logic [1:0]  cfg_edge;
  logic [15:0] cfg_holdoff;
  logic [23:0] cfg_timeout;
  logic        arm, cmp_in, buf_ready, buf_done;
  logic        sample_tick, capture_start, capture_en, forced;
  logic [1:0]  state;
  logic [15:0] frame_cnt;
  logic [21:0] obs;

  always #5 clk = ~clk;

  acq_trigger_ctrl #(.DIV_WIDTH(16), .HOLDOFF_WIDTH(16), .TIMEOUT_WIDTH(24)) dut (
    .clk(clk), .rst(rst), .cfg_div(cfg_div), .cfg_mode(cfg_mode), .cfg_edge(cfg_edge),
    .cfg_holdoff(cfg_holdoff), .cfg_timeout(cfg_timeout), .arm(arm), .cmp_in(cmp_in),
    .buf_ready(buf_ready), .buf_done(buf_done), .sample_tick(sample_tick),
    .capture_start(capture_start), .capture_en(capture_en), .forced(forced),
    .state(state), .frame_cnt(frame_cnt)
  );

  assign obs = {sample_tick, capture_start, capture_en, forced, state, frame_cnt};

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model: phase numbers follow the visible state output (0 idle .. 3 holdoff)
  int     m_cyc, m_state, m_frames, m_ho;
  longint m_armed;
  bit     m_tick, m_start, m_en, m_forced, m_prev;
  localparam longint TO_MAX = 64'd16777215;

  task automatic model_reset();
    m_cyc = 0; m_state = 0; m_frames = 0; m_ho = 0; m_armed = 0;
    m_tick = 0; m_start = 0; m_en = 0; m_forced = 0; m_prev = 0;
  endtask

  // Advance the model by one clock using the inputs present at that edge
  task automatic model_clock();
    bit was_tick, up, dn, trig;
    was_tick = m_tick;
    up = was_tick && cmp_in && !m_prev;
    dn = was_tick && !cmp_in && m_prev;
    case (cfg_edge)
      2'd0: trig = up;
      2'd1: trig = dn;
      2'd2: trig = up || dn;
      default: trig = was_tick;
    endcase
    if (was_tick) m_prev = cmp_in;
    m_start = 0;
    case (m_state)
      0: if (cfg_mode < 2'd2 || (cfg_mode == 2'd2 && arm)) begin m_state = 1; m_armed = 0; end
      1: begin
        if (cfg_mode == 2'd3) m_state = 0;
        else if (was_tick && buf_ready &&
                 (trig || (cfg_mode == 2'd1 && m_armed >= longint'(cfg_timeout)))) begin
          m_state = 2; m_start = 1; m_forced = !trig;
        end
        if (was_tick && m_armed < TO_MAX) m_armed++;
      end
      2: begin
        if (buf_done) begin
          m_frames = (m_frames + 1) % 65536;
          m_state  = (cfg_mode >= 2'd2) ? 0 : 3;
          m_ho     = 0;
        end else if (cfg_mode == 2'd3) m_state = 0;
      end
      default: begin
        if (cfg_mode == 2'd3) m_state = 0;
        else if (m_ho >= int'(cfg_holdoff)) begin m_state = 1; m_armed = 0; end
        else if (was_tick) m_ho++;
      end
    endcase
    m_en = (m_state == 2);
    m_cyc++;
    m_tick = (m_cyc % (int'(cfg_div) + 1)) == 0;
  endtask

  function automatic logic [21:0] exp_vec();
    logic [1:0]  st;
    logic [15:0] fc;
    st = m_state[1:0];
    fc = m_frames[15:0];
    return {m_tick, m_start, m_en, m_forced, st, fc};
  endfunction

  task automatic step();
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    model_reset();
  endtask

  task automatic idle_inputs();
    arm = 1'b0; cmp_in = 1'b0; buf_ready = 1'b1; buf_done = 1'b0;
  endtask

  task automatic test_reset();
    cfg_div = 16'd3; cfg_mode = 2'd0; cfg_edge = 2'd0; cfg_holdoff = 16'd2; cfg_timeout = 24'd0;
    idle_inputs();
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (obs !== 22'd0) begin n_err++; $display("FAIL reset_values got=%h want=%h", obs, 22'd0); end
    @(negedge clk); rst = 1'b0;
    model_reset();
    for (int c = 0; c < 8; c++) begin
      step();
      n_cmp++;
      if (obs !== exp_vec()) begin n_err++; $display("FAIL reset_run c=%0d got=%h want=%h", c, obs, exp_vec()); end
    end
  endtask

  task automatic test_normal();
    int since, last_tick;
    since = 0; last_tick = -1;
    cfg_div = 16'd3; cfg_mode = 2'd0; cfg_edge = 2'd0; cfg_holdoff = 16'd2;
    idle_inputs();
    apply_reset();
    for (int c = 0; c < 800 && m_frames < 3; c++) begin
      cmp_in   = ((c / 20) % 2) == 1;
      buf_done = (since == 40);
      if (buf_done) since = 0;
      step();
      n_cmp++;
      if (obs !== exp_vec()) begin n_err++; $display("FAIL normal c=%0d got=%h want=%h", c, obs, exp_vec()); end
      if (m_start) since = 1; else if (since > 0) since++;
      if (sample_tick === 1'b1) begin
        if (last_tick >= 0) begin
          n_cmp++;
          if (c - last_tick != 4) begin n_err++; $display("FAIL tick_period gap=%0d want=4", c - last_tick); end
        end
        last_tick = c;
      end
      if (state === 2'd3) begin
        n_cmp++;
        if (capture_start !== 1'b0) begin n_err++; $display("FAIL holdoff_trigger got=%b want=0", capture_start); end
      end
    end
    n_cmp++;
    if (frame_cnt !== 16'd3) begin n_err++; $display("FAIL normal_frames got=%0d want=3", frame_cnt); end
  endtask

  task automatic test_auto();
    int phase, since, armed_ticks;
    phase = 0; since = 0; armed_ticks = 0;
    cfg_div = 16'd3; cfg_mode = 2'd1; cfg_edge = 2'd0; cfg_holdoff = 16'd0; cfg_timeout = 24'd10;
    idle_inputs();
    apply_reset();
    for (int c = 0; c < 400 && phase < 3; c++) begin
      buf_done = (phase == 1 && since == 5);
      cmp_in   = (phase == 2 && since >= 3);
      step();
      n_cmp++;
      if (obs !== exp_vec()) begin n_err++; $display("FAIL auto c=%0d got=%h want=%h", c, obs, exp_vec()); end
      since++;
      case (phase)
        0: begin
          if (m_start) begin
            n_cmp++;
            if (capture_start !== 1'b1 || forced !== 1'b1 || armed_ticks != 11)
              begin n_err++; $display("FAIL auto_forced start=%b forced=%b ticks=%0d want 1/1/11", capture_start, forced, armed_ticks); end
            phase = 1; since = 0;
          end else if (state === 2'd1 && sample_tick === 1'b1) armed_ticks++;
        end
        1: if (m_state == 1) begin phase = 2; since = 0; end
        2: if (m_start) begin
          n_cmp++;
          if (capture_start !== 1'b1 || forced !== 1'b0)
            begin n_err++; $display("FAIL auto_edge start=%b forced=%b want 1/0", capture_start, forced); end
          phase = 3;
        end
        default: ;
      endcase
    end
    n_cmp++;
    if (phase != 3) begin n_err++; $display("FAIL auto_budget phase=%0d want=3", phase); end
  endtask

  task automatic test_single();
    int phase, en_cnt, p2;
    phase = 0; en_cnt = 0; p2 = 0;
    cfg_div = 16'd1; cfg_mode = 2'd2; cfg_edge = 2'd0; cfg_holdoff = 16'd1;
    idle_inputs();
    apply_reset();
    for (int c = 0; c < 200 && phase < 3; c++) begin
      cmp_in   = ((c / 4) % 2) == 1;
      arm      = (c == 24) || (m_state == 2 && en_cnt == 1);
      buf_done = (m_state == 2 && en_cnt == 3);
      step();
      n_cmp++;
      if (obs !== exp_vec()) begin n_err++; $display("FAIL single c=%0d got=%h want=%h", c, obs, exp_vec()); end
      en_cnt = m_en ? en_cnt + 1 : 0;
      case (phase)
        0: begin
          n_cmp++;
          if (state !== 2'd0 || capture_start !== 1'b0)
            begin n_err++; $display("FAIL single_idle state=%0d start=%b want 0/0", state, capture_start); end
          if (c == 23) phase = 1;
        end
        1: if (m_frames == 1 && m_state == 0) begin
          n_cmp++;
          if (frame_cnt !== 16'd1 || state !== 2'd0)
            begin n_err++; $display("FAIL single_done frames=%0d state=%0d want 1/0", frame_cnt, state); end
          phase = 2;
        end
        2: begin
          n_cmp++;
          if (capture_start !== 1'b0) begin n_err++; $display("FAIL single_noarm start=%b want=0", capture_start); end
          p2++;
          if (p2 == 30) phase = 3;
        end
        default: ;
      endcase
    end
    arm = 1'b0;
    n_cmp++;
    if (phase != 3) begin n_err++; $display("FAIL single_budget phase=%0d want=3", phase); end
  endtask

  task automatic test_ready_gate();
    int first;
    first = -1;
    cfg_div = 16'd1; cfg_mode = 2'd0; cfg_edge = 2'd0; cfg_holdoff = 16'd0;
    idle_inputs();
    buf_ready = 1'b0;
    apply_reset();
    for (int c = 0; c < 70; c++) begin
      cmp_in    = ((c / 6) % 2) == 1;
      buf_ready = (c >= 33);
      buf_done  = (m_state == 2);
      step();
      n_cmp++;
      if (obs !== exp_vec()) begin n_err++; $display("FAIL gate c=%0d got=%h want=%h", c, obs, exp_vec()); end
      if (c < 42) begin
        n_cmp++;
        if (capture_start !== 1'b0) begin n_err++; $display("FAIL gate_hold c=%0d start=%b want=0", c, capture_start); end
      end
      if (capture_start === 1'b1 && first < 0) first = c;
    end
    n_cmp++;
    if (first < 42 || first > 46) begin n_err++; $display("FAIL gate_release first=%0d want 42..46", first); end
  endtask

  task automatic test_abort();
    cfg_div = 16'd1; cfg_mode = 2'd0; cfg_edge = 2'd3; cfg_holdoff = 16'd0;
    idle_inputs();
    apply_reset();
    for (int k = 0; k < 20 && !m_en; k++) step();
    step();
    n_cmp++;
    if (capture_en !== 1'b1) begin n_err++; $display("FAIL abort_setup en=%b want=1", capture_en); end
    cfg_mode = 2'd3;
    step();
    n_cmp++;
    if (capture_en !== 1'b0 || state !== 2'd0 || frame_cnt !== 16'd0)
      begin n_err++; $display("FAIL abort en=%b state=%0d frames=%0d want 0/0/0", capture_en, state, frame_cnt); end
    cfg_mode = 2'd0;
    for (int k = 0; k < 20 && !m_en; k++) step();
    cfg_mode = 2'd3; buf_done = 1'b1;
    step();
    n_cmp++;
    if (frame_cnt !== 16'd1 || state !== 2'd0 || capture_en !== 1'b0)
      begin n_err++; $display("FAIL done_with_stop frames=%0d state=%0d en=%b want 1/0/0", frame_cnt, state, capture_en); end
    cfg_mode = 2'd0; buf_done = 1'b0;
    for (int k = 0; k < 20 && !m_en; k++) begin
      step();
      n_cmp++;
      if (obs !== exp_vec()) begin n_err++; $display("FAIL abort_rearm k=%0d got=%h want=%h", k, obs, exp_vec()); end
    end
    step();
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (obs !== 22'd0) begin n_err++; $display("FAIL reset_midframe got=%h want=%h", obs, 22'd0); end
    @(negedge clk); rst = 1'b0;
    model_reset();
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      cfg_div     = 16'($urandom_range(0, 3));
      cfg_mode    = 2'($urandom_range(0, 1));
      cfg_edge    = 2'($urandom_range(0, 3));
      cfg_holdoff = 16'($urandom_range(0, 3));
      cfg_timeout = 24'($urandom_range(0, 15));
      idle_inputs();
      apply_reset();
      for (int c = 0; c < 300; c++) begin
        if ($urandom_range(0, 4) == 0) cmp_in = ~cmp_in;
        buf_ready = ($urandom_range(0, 9) != 0);
        buf_done  = ($urandom_range(0, 5) == 0);
        arm       = ($urandom_range(0, 7) == 0);
        if ($urandom_range(0, 49) == 0) cfg_mode = 2'($urandom_range(0, 3));
        step();
        n_cmp++;
        if (obs !== exp_vec()) begin n_err++; $display("FAIL random r=%0d c=%0d got=%h want=%h", r, c, obs, exp_vec()); end
      end
    end
  endtask

  task automatic test_div0_wrap();
    bit seen_top, wrapped;
    seen_top = 0; wrapped = 0;
    cfg_div = 16'd0; cfg_mode = 2'd0; cfg_edge = 2'd3; cfg_holdoff = 16'd0;
    idle_inputs();
    buf_done = 1'b1;
    apply_reset();
    for (int c = 0; c < 200000 && !wrapped; c++) begin
      step();
      n_cmp++;
      if (obs !== exp_vec()) begin n_err++; $display("FAIL wrap_run c=%0d got=%h want=%h", c, obs, exp_vec()); end
      if (c < 50) begin
        n_cmp++;
        if (sample_tick !== 1'b1) begin n_err++; $display("FAIL div0_tick c=%0d got=%b want=1", c, sample_tick); end
      end
      if (!seen_top && m_frames == 65535) begin
        seen_top = 1;
        n_cmp++;
        if (frame_cnt !== 16'hFFFF) begin n_err++; $display("FAIL frames_top got=%h want=ffff", frame_cnt); end
      end else if (seen_top && m_frames == 0) begin
        wrapped = 1;
        n_cmp++;
        if (frame_cnt !== 16'h0000) begin n_err++; $display("FAIL frames_wrap got=%h want=0000", frame_cnt); end
      end
    end
    n_cmp++;
    if (!wrapped) begin n_err++; $display("FAIL wrap_budget wrapped=%0d want=1", wrapped); end
    buf_done = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    cfg_div = '0; cfg_mode = '0; cfg_edge = '0; cfg_holdoff = '0; cfg_timeout = '0;
    idle_inputs();
    model_reset();
    test_reset();
    test_normal();
    test_auto();
    test_single();
    test_ready_gate();
    test_abort();
    test_random();
    test_div0_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
